// File: rtl/ext_stage_fifo.sv
// Immediate-extension stage with a DEPTH-entry output queue, sitting between decode and execute.
// Optional EXT_BAD_OP_EN: store a per-entry reserved-op flag and present it on out_bad.
module ext_stage_fifo #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W-1:0]            in_imm,
    input  logic [2:0]                 in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_bad,
    output logic [$clog2(DEPTH):0]     out_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [OUT_W-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg, last_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             full, empty, push, pop;
    logic [OUT_W-1:0] zext_data, sext_data, ext_data;
    logic [OUT_W-1:0] hi_mask;

    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_count = count_reg;
    assign push      = in_valid && !full;
    assign pop       = !empty && out_ready;

    // hi_mask covers bits [OUT_W-1:IN_W]; collapses to zero when OUT_W == IN_W.
    assign hi_mask   = ~((OUT_W'(1) << IN_W) - OUT_W'(1));
    assign zext_data = OUT_W'(in_imm);
    assign sext_data = zext_data | (in_imm[IN_W-1] ? hi_mask : '0);

    always_comb begin
        ext_data = '0;
        case (in_op)
            3'd0:    ext_data = zext_data;
            3'd1:    ext_data = sext_data;
            3'd2:    ext_data = zext_data << (OUT_W - IN_W);
            3'd3:    ext_data = sext_data << 2;
            default: ext_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            last_ptr_reg <= '0;
            count_reg    <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg   <= wr_ptr_reg + PW'(1);
                last_ptr_reg <= wr_ptr_reg;
            end
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    mem_reg[gi] <= '0;
                else if (push && !flush && (wr_ptr_reg == PW'(gi)))
                    mem_reg[gi] <= ext_data;
            end
        end
    endgenerate

    // When empty, show the most recently written slot rather than a stale one.
    assign out_data = empty ? mem_reg[last_ptr_reg] : mem_reg[rd_ptr_reg];

`ifdef EXT_BAD_OP_EN
    logic bad_reg [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bad
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    bad_reg[gi] <= 1'b0;
                else if (push && !flush && (wr_ptr_reg == PW'(gi)))
                    bad_reg[gi] <= in_op[2];
            end
        end
    endgenerate

    assign out_bad = empty ? bad_reg[last_ptr_reg] : bad_reg[rd_ptr_reg];
`else
    assign out_bad = 1'b0;
`endif

endmodule

// File: tb/tb_ext_stage_fifo.sv
// Directed bench for ext_stage_fifo (IN_W=16, OUT_W=32, DEPTH=2).
module tb_ext_stage_fifo;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [15:0] in_imm;
    logic [2:0]  in_op;
    logic        in_ready, out_valid, out_bad;
    logic [31:0] out_data;
    logic [1:0]  out_count;

    int checks = 0;
    int errors = 0;

`ifdef EXT_BAD_OP_EN
    localparam logic EXP_BAD = 1'b1;
`else
    localparam logic EXP_BAD = 1'b0;
`endif

    always #5 clk = ~clk;

    ext_stage_fifo #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bad(out_bad), .out_count(out_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] imm, input logic [2:0] op, input logic rdy);
        in_valid  = v;
        in_imm    = imm;
        in_op     = op;
        out_ready = rdy;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        tick(); tick();
        reset = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready),  32'd1);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_data",  out_data,       32'h0);
        check("rst_bad",   32'(out_bad),   32'd0);

        // One op per cycle with the consumer always ready.
        drive(1'b1, 16'h8001, 3'd1, 1'b1); tick();
        check("sign", out_data, 32'hFFFF8001);
        check("sign_cnt", 32'(out_count), 32'd1);
        drive(1'b1, 16'h8001, 3'd0, 1'b1); tick();
        check("zero", out_data, 32'h00008001);
        drive(1'b1, 16'h8001, 3'd2, 1'b1); tick();
        check("upper", out_data, 32'h80010000);
        drive(1'b1, 16'h8001, 3'd3, 1'b1); tick();
        check("branch", out_data, 32'hFFFE0004);
        check("branch_cnt", 32'(out_count), 32'd1);
        drive(1'b0, 16'h0, 3'd0, 1'b1); tick();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Fill with consumer stalled.
        drive(1'b1, 16'h0001, 3'd0, 1'b0); tick();
        drive(1'b1, 16'h0002, 3'd0, 1'b0); tick();
        check("full_ready", 32'(in_ready),  32'd0);
        check("full_count", 32'(out_count), 32'd2);
        check("full_head",  out_data,       32'h1);
        drive(1'b1, 16'h0003, 3'd0, 1'b0); tick();
        check("full_nopush_cnt", 32'(out_count), 32'd2);
        // Pop while full: the offered push must still be refused.
        drive(1'b1, 16'h0003, 3'd0, 1'b1); tick();
        check("popfull_cnt",  32'(out_count), 32'd1);
        check("popfull_head", out_data,       32'h2);
        drive(1'b0, 16'h0, 3'd0, 1'b1); tick();
        check("popfull_empty", 32'(out_count), 32'd0);

        // Streaming across pointer wrap.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(16'h0010 + i), 3'd0, 1'b1); tick();
            check($sformatf("stream%0d", i), out_data, 32'h10 + 32'(i));
            check($sformatf("stream_cnt%0d", i), 32'(out_count), 32'd1);
        end
        drive(1'b0, 16'h0, 3'd0, 1'b1); tick();
        check("stream_empty", 32'(out_count), 32'd0);

        // Flush while full with a push offered.
        drive(1'b1, 16'h00A1, 3'd0, 1'b0); tick();
        drive(1'b1, 16'h00A2, 3'd0, 1'b0); tick();
        check("pre_flush_cnt", 32'(out_count), 32'd2);
        flush = 1'b1;
        drive(1'b1, 16'h00AA, 3'd0, 1'b1); tick();
        flush = 1'b0;
        check("flush_cnt",   32'(out_count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready),  32'd1);
        // Flush with a non-full push offered: push discarded too.
        flush = 1'b1;
        drive(1'b1, 16'h00BB, 3'd0, 1'b0); tick();
        flush = 1'b0;
        check("flush_push_cnt", 32'(out_count), 32'd0);
        drive(1'b1, 16'h0055, 3'd0, 1'b0); tick();
        check("post_flush_head", out_data,       32'h55);
        check("post_flush_cnt",  32'(out_count), 32'd1);
        drive(1'b0, 16'h0, 3'd0, 1'b1); tick();
        check("post_flush_empty", 32'(out_count), 32'd0);

        // Reserved op, then a second entry, then asynchronous reset.
        drive(1'b1, 16'hFFFF, 3'd5, 1'b0); tick();
        check("bad_valid", 32'(out_valid), 32'd1);
        check("bad_data",  out_data,       32'h0);
        check("bad_flag",  32'(out_bad),   32'(EXP_BAD));
        drive(1'b1, 16'h8001, 3'd1, 1'b0); tick();
        check("bad_hold_cnt", 32'(out_count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(out_count), 32'd0);
        check("arst_data",  out_data,       32'h0);
        check("arst_ready", 32'(in_ready),  32'd1);
        check("arst_bad",   32'(out_bad),   32'd0);
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check("post_arst_cnt", 32'(out_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
